load_ext_pipe: RTL and testbench

- Parametrised load-data extraction and extension unit for the CPU memory/writeback path.
- Takes a raw memory word, the low address bits, a load mode and the old destination register value.
- Selects the addressed byte, half or word lanes and zero- or sign-extends them, or performs LWL/LWR partial merges.
- Result is registered behind a valid/ready handshake with a one-entry skid buffer, so the unit can stall without a combinational ready path.

---
 rtl/load_ext_pipe_pkg.sv | 22 ++
 rtl/load_ext_pipe_lane_sel.sv | 72 +++++++
 rtl/load_ext_pipe.sv | 113 +++++++++++
 tb/tb_load_ext_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_ext_pipe_pkg.sv
// Shared load-mode encodings and width derivations for the load-data path.
// Imported by the load extraction unit and by the CPU decoder.
package load_ext_pipe_pkg;

  localparam logic [2:0] LM_LB  = 3'd0;
  localparam logic [2:0] LM_LBU = 3'd1;
  localparam logic [2:0] LM_LH  = 3'd2;
  localparam logic [2:0] LM_LHU = 3'd3;
  localparam logic [2:0] LM_LW  = 3'd4;
  localparam logic [2:0] LM_LWL = 3'd5;
  localparam logic [2:0] LM_LWR = 3'd6;
  localparam logic [2:0] LM_RSV = 3'd7;

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/load_ext_pipe_lane_sel.sv
// Combinational lane select, sign/zero extension and LWL/LWR merge for one load.
// Misaligned half/word loads and the reserved mode flag an error and return zero.
module load_lane_sel
  import load_ext_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = off_w_of(DATA_W)
) (
  input  logic [2:0]        mode,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] mem,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  localparam int SH_W = OFF_W + 3;

  logic [SH_W-1:0]   rsh;
  logic [SH_W-1:0]   lsh;
  logic [DATA_W-1:0] mem_dn;
  logic [DATA_W-1:0] mem_up;
  logic [DATA_W-1:0] keep_lo;
  logic [DATA_W-1:0] keep_hi;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // LWR shifts memory down by k bytes; LWL shifts it up by (NB-1-k) bytes, and ~k == NB-1-k
  assign rsh     = {off, 3'b000};
  assign lsh     = {~off, 3'b000};
  assign mem_dn  = mem >> rsh;
  assign mem_up  = mem << lsh;
  assign keep_lo = ~({DATA_W{1'b1}} << lsh);
  assign keep_hi = ~({DATA_W{1'b1}} >> rsh);
  assign byte_v  = mem_dn[7:0];
  assign half_v  = mem_dn[15:0];

  // Mode decode: pick lanes, extend or merge, flag misalignment
  always_comb begin
    data = {DATA_W{1'b0}};
    err  = 1'b0;
    case (mode)
      LM_LB:  data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LM_LBU: data = {{(DATA_W-8){1'b0}}, byte_v};
      LM_LH: begin
        if (off[0]) begin
          err = 1'b1;
        end else begin
          data = {{(DATA_W-16){half_v[15]}}, half_v};
        end
      end
      LM_LHU: begin
        if (off[0]) begin
          err = 1'b1;
        end else begin
          data = {{(DATA_W-16){1'b0}}, half_v};
        end
      end
      LM_LW: begin
        if (off != {OFF_W{1'b0}}) begin
          err = 1'b1;
        end else begin
          data = mem;
        end
      end
      LM_LWL: data = mem_up | (rt & keep_lo);
      LM_LWR: data = mem_dn | (rt & keep_hi);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_ext_pipe.sv
// Registered load extraction stage with a one-entry skid buffer so in_ready
// comes straight from a flop; also counts errored results delivered downstream.
module load_ext_pipe
  import load_ext_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OFF_W    = off_w_of(DATA_W),
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_mode,
  input  logic [OFF_W-1:0]    in_off,
  input  logic [DATA_W-1:0]   in_mem,
  input  logic [DATA_W-1:0]   in_rt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              acc_in;
  logic              acc_out;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;

  logic              out_valid_nx;
  logic [DATA_W-1:0] out_data_nx;
  logic              out_err_nx;
  logic              skid_valid_nx;
  logic [DATA_W-1:0] skid_data_nx;
  logic              skid_err_nx;

  load_lane_sel #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_lane_sel (
    .mode (in_mode),
    .off  (in_off),
    .mem  (in_mem),
    .rt   (in_rt),
    .data (res_data),
    .err  (res_err)
  );

  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;

  // Output/skid next state: the output slot refills from skid first, else from the new result
  always_comb begin
    out_valid_nx  = out_valid;
    out_data_nx   = out_data;
    out_err_nx    = out_err;
    skid_valid_nx = skid_valid;
    skid_data_nx  = skid_data;
    skid_err_nx   = skid_err;
    if (!out_valid || acc_out) begin
      if (skid_valid) begin
        out_valid_nx  = 1'b1;
        out_data_nx   = skid_data;
        out_err_nx    = skid_err;
        skid_valid_nx = 1'b0;
      end else if (acc_in) begin
        out_valid_nx = 1'b1;
        out_data_nx  = res_data;
        out_err_nx   = res_err;
      end else begin
        out_valid_nx = 1'b0;
      end
    end else if (acc_in) begin
      skid_valid_nx = 1'b1;
      skid_data_nx  = res_data;
      skid_err_nx   = res_err;
    end else begin
      skid_valid_nx = skid_valid;
    end
  end

  // Pipeline registers and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= {DATA_W{1'b0}};
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= {DATA_W{1'b0}};
      skid_err   <= 1'b0;
      in_ready   <= 1'b1;
      err_count  <= {ERRCNT_W{1'b0}};
    end else begin
      out_valid  <= out_valid_nx;
      out_data   <= out_data_nx;
      out_err    <= out_err_nx;
      skid_valid <= skid_valid_nx;
      skid_data  <= skid_data_nx;
      skid_err   <= skid_err_nx;
      in_ready   <= ~skid_valid_nx;
      if (acc_out && out_err && (err_count != {ERRCNT_W{1'b1}})) begin
        err_count <= err_count + ERRCNT_W'(1);
      end else begin
        err_count <= err_count;
      end
    end
  end

endmodule

// File: tb/tb_load_ext_pipe.sv
// Directed self-checking bench for load_ext_pipe: lane functions, backpressure,
// reset flush, error-counter saturation and a 64-bit instance.
module tb_load_ext_pipe;
  import load_ext_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // default instance
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_mode;
  logic [1:0]  in_off;
  logic [31:0] in_mem, in_rt, out_data;
  logic [7:0]  err_count;

  // ERRCNT_W = 2 instance
  logic        e_valid, e_in_ready, e_out_valid, e_ready, e_err;
  logic [2:0]  e_mode;
  logic [1:0]  e_off;
  logic [31:0] e_mem, e_rt, e_data;
  logic [1:0]  e_count;

  // DATA_W = 64 instance
  logic        w_valid, w_in_ready, w_out_valid, w_ready, w_err;
  logic [2:0]  w_mode;
  logic [2:0]  w_off;
  logic [63:0] w_mem, w_rt, w_data;
  logic [7:0]  w_count;

  load_ext_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_off(in_off), .in_mem(in_mem), .in_rt(in_rt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_count(err_count)
  );

  load_ext_pipe #(.ERRCNT_W(2)) dut_e (
    .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(e_in_ready),
    .in_mode(e_mode), .in_off(e_off), .in_mem(e_mem), .in_rt(e_rt),
    .out_valid(e_out_valid), .out_ready(e_ready), .out_data(e_data),
    .out_err(e_err), .err_count(e_count)
  );

  load_ext_pipe #(.DATA_W(64)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_in_ready),
    .in_mode(w_mode), .in_off(w_off), .in_mem(w_mem), .in_rt(w_rt),
    .out_valid(w_out_valid), .out_ready(w_ready), .out_data(w_data),
    .out_err(w_err), .err_count(w_count)
  );

  // byte-wise reference for the 64-bit instance
  function automatic logic [63:0] model64(input logic [2:0] mode, input int k,
                                          input logic [63:0] mem, input logic [63:0] rt);
    logic [63:0] r;
    r = 64'd0;
    case (mode)
      LM_LB: r = {{56{mem[8*k+7]}}, mem[8*k +: 8]};
      LM_LWL: for (int j = 0; j < 8; j++)
        r[8*j +: 8] = (j >= 7 - k) ? mem[8*(j-(7-k)) +: 8] : rt[8*j +: 8];
      LM_LWR: for (int j = 0; j < 8; j++)
        r[8*j +: 8] = (j < 8 - k) ? mem[8*(j+k) +: 8] : rt[8*j +: 8];
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rdy=%b d=%h e=%b, expected v=0 rdy=1 d=0 e=0",
               out_valid, in_ready, out_data, out_err);
    end
    n_checks++;
    if (err_count !== 8'd0 || e_count !== 2'd0 || w_out_valid !== 1'b0 || e_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_aux: got cnt=%h ecnt=%h wv=%b ev=%b, expected all 0",
               err_count, e_count, w_out_valid, e_out_valid);
    end
    rst = 1'b0;
  endtask

  logic [2:0]  v_mode [12];
  logic [1:0]  v_off  [12];
  logic [31:0] v_mem  [12];
  logic [31:0] v_rt   [12];
  logic [31:0] v_exp  [12];
  logic        v_err  [12];

  task automatic test_lanes();
    logic [7:0] exp_cnt;
    v_mode = '{LM_LB, LM_LBU, LM_LH, LM_LHU, LM_LWL, LM_LWR, LM_RSV, LM_LW, LM_LW, LM_LWL, LM_LWR, LM_LHU};
    v_off  = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    v_mem  = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_0000, 32'h8001_0000, 32'hAABB_CCDD,
               32'hAABB_CCDD, 32'hAABB_CCDD, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hAABB_CCDD,
               32'hAABB_CCDD, 32'h8001_0000};
    v_rt   = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h1122_3344, 32'h1122_3344, 32'd0, 32'd0, 32'd0,
               32'h1122_3344, 32'h1122_3344, 32'd0};
    v_exp  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_0000, 32'hCCDD_3344,
               32'h11AA_BBCC, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 32'hAABB_CCDD,
               32'hAABB_CCDD, 32'h0000_8001};
    v_err  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_cnt = 8'd0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_mode  = v_mode[i];
      in_off   = v_off[i];
      in_mem   = v_mem[i];
      in_rt    = v_rt[i];
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== v_exp[i] || out_err !== v_err[i]) begin
        n_fail++;
        $display("FAIL lane_%0d: got v=%b d=%h e=%b, expected v=1 d=%h e=%b",
                 i, out_valid, out_data, out_err, v_exp[i], v_err[i]);
      end
      n_checks++;
      if (err_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL errcnt_%0d: got %0d expected %0d", i, err_count, exp_cnt);
      end
      if (v_err[i]) exp_cnt++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd3) begin
      n_fail++;
      $display("FAIL lanes_drain: got v=%b cnt=%0d expected v=0 cnt=3", out_valid, err_count);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] vals [4];
    logic [31:0] got [$];
    int  idx;
    bit  sent;
    vals = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    idx = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = LM_LW;
    in_off    = 2'd0;
    in_rt     = 32'd0;
    in_mem    = vals[0];
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 6) begin
        n_checks++;
        if (idx !== 2) begin
          n_fail++;
          $display("FAIL stall_accepts: got %0d accepts expected 2", idx);
        end
        out_ready = 1'b1;
      end
      if (!out_ready && idx >= 2) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== vals[0]) begin
          n_fail++;
          $display("FAIL stall_hold: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=%h",
                   in_ready, out_valid, out_data, vals[0]);
        end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      sent = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (sent) begin
        idx++;
        if (idx == 4) in_valid = 1'b0;
        else in_mem = vals[idx];
      end
      @(negedge clk);
      if (got.size() == 4) break;
    end
    n_checks++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got[i] !== vals[i]) begin
          n_fail++;
          $display("FAIL stream_order_%0d: got %h expected %h", i, got[i], vals[i]);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_drain: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = LM_LW;
    in_off    = 2'd0;
    in_mem    = 32'h5555_0001;
    @(negedge clk);
    in_mem    = 32'h5555_0002;
    @(negedge clk);
    in_valid  = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || err_count !== 8'd3) begin
      n_fail++;
      $display("FAIL flush_full: got rdy=%b v=%b cnt=%0d expected rdy=0 v=1 cnt=3",
               in_ready, out_valid, err_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL flush_reset: got v=%b rdy=%b cnt=%0d expected v=0 rdy=1 cnt=0",
               out_valid, in_ready, err_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_ghost_%0d: got v=%b d=%h expected v=0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_err_saturation();
    @(negedge clk);
    e_ready = 1'b1;
    e_valid = 1'b1;
    e_mode  = LM_RSV;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (e_out_valid !== 1'b1 || e_err !== 1'b1 || e_data !== 32'd0) begin
        n_fail++;
        $display("FAIL sat_out_%0d: got v=%b e=%b d=%h expected v=1 e=1 d=0",
                 i, e_out_valid, e_err, e_data);
      end
    end
    e_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (e_count !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_count: got %0d expected 3", e_count);
    end
  endtask

  task automatic test_wide();
    logic [2:0]  modes [3];
    int          offs  [3];
    logic [63:0] exp_d;
    modes = '{LM_LWL, LM_LB, LM_LWR};
    offs  = '{5, 7, 3};
    w_ready = 1'b1;
    w_mem   = 64'h8877_6655_4433_2211;
    w_rt    = 64'hFFEE_DDCC_BBAA_9988;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_mode  = modes[i];
      w_off   = offs[i][2:0];
      exp_d   = model64(modes[i], offs[i], w_mem, w_rt);
      @(negedge clk);
      w_valid = 1'b0;
      n_checks++;
      if (w_out_valid !== 1'b1 || w_data !== exp_d || w_err !== 1'b0) begin
        n_fail++;
        $display("FAIL wide_%0d: got v=%b d=%h e=%b expected v=1 d=%h e=0",
                 i, w_out_valid, w_data, w_err, exp_d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_mode = 3'd0; in_off = 2'd0; in_mem = 32'd0; in_rt = 32'd0; out_ready = 1'b1;
    e_valid = 1'b0; e_mode = 3'd0; e_off = 2'd0; e_mem = 32'd0; e_rt = 32'd0; e_ready = 1'b1;
    w_valid = 1'b0; w_mode = 3'd0; w_off = 3'd0; w_mem = 64'd0; w_rt = 64'd0; w_ready = 1'b1;
    test_reset();
    test_lanes();
    test_back_to_back_stall();
    test_reset_flush();
    test_err_saturation();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
